seg7_scan_display: RTL and testbench

- Reader side of the meter's 12-bit display word {mantissa_hi[11:8], mantissa_lo[7:4], exponent[3:0]}.
- Waits until the word has been stable for a set time, latches it, then time-multiplexes it onto a 4-digit common-anode 7-segment display as "M1 M0 E X".
- Blanks all anodes at the start of each digit slot to prevent ghosting.

---
 rtl/seg7_pkg.sv | 31 +++
 rtl/seg7_decode.sv | 20 ++
 rtl/seg7_scan_display.sv | 121 ++++++++++++
 tb/tb_seg7_scan_display.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and segment patterns for the seg7 scan display.
// Patterns are active-high in {g,f,e,d,c,b,a} order.
package seg7_pkg;

  typedef logic [1:0] digit_idx_t;

  typedef enum logic {S_BLANK, S_DRIVE} scan_state_t;

  typedef enum logic [1:0] {KIND_MANT, KIND_EXP, KIND_LETTER_E} digit_kind_t;

  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] bcd_pattern(input logic [3:0] code);
    case (code)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit decoder: code + kind -> active-high segment pattern.
// Out-of-range mantissa (A-F) and exponent (6-F) codes show a dash.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0]  i_code,
  input  digit_kind_t i_kind,
  output logic [6:0]  o_pat
);

  always_comb begin
    o_pat = SEG_DASH;
    case (i_kind)
      KIND_LETTER_E: o_pat = SEG_E;
      KIND_EXP:      if (i_code < 4'd6)  o_pat = bcd_pattern(i_code);
      default:       if (i_code < 4'd10) o_pat = bcd_pattern(i_code);
    endcase
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Debounced latch of the 12-bit meter word and 4-digit multiplexed scan "M1 M0 E X".
// Optional build macro SEG7_LEADING_BLANK_EN suppresses a leading zero on the top digit.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int CLK_DIV        = 50000,
  parameter int BLANK_CYC      = 500,
  parameter int STABLE_CNT     = 4,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] lcd_in,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        upd
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW = $clog2(STABLE_CNT + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PRESC_BLNK = PW'(BLANK_CYC);
  localparam logic [SW-1:0] STAB_MAX   = SW'(STABLE_CNT);
  localparam logic [SW-1:0] STAB_LAST  = SW'(STABLE_CNT - 1);
  localparam bit            ACT_LOW    = (SEG_ACTIVE_LOW != 0);
  localparam logic [6:0]    SEG_OFF    = ACT_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0]    AN_OFF     = ACT_LOW ? 4'hF : 4'h0;

  logic [11:0]   r_prev;
  logic [11:0]   r_disp;
  logic [SW-1:0] r_stab;
  logic          r_upd;

  logic [PW-1:0] r_presc;
  digit_idx_t    r_idx;
  scan_state_t   r_state;
  logic [6:0]    r_seg;
  logic [3:0]    r_an;

  logic [PW-1:0] w_presc_next;
  logic          w_wrap;
  logic [3:0]    w_code;
  digit_kind_t   w_kind;
  logic [6:0]    w_pat;
  logic [3:0]    w_an_onehot;
  logic          w_digit_on;

  // A value is accepted only after STABLE_CNT matching samples, and only if it differs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= 12'h000;
      r_stab <= '0;
      r_disp <= 12'h000;
      r_upd  <= 1'b0;
    end else begin
      r_prev <= lcd_in;
      if (lcd_in != r_prev)
        r_stab <= '0;
      else if (r_stab != STAB_MAX)
        r_stab <= r_stab + 1'b1;
      r_upd <= 1'b0;
      if (r_stab == STAB_LAST && r_prev != r_disp) begin
        r_disp <= r_prev;
        r_upd  <= 1'b1;
      end
    end
  end

  always_comb begin
    w_code = 4'h0;
    w_kind = KIND_MANT;
    case (r_idx)
      2'd0: begin w_code = r_disp[3:0];  w_kind = KIND_EXP;      end
      2'd1: begin w_code = 4'h0;         w_kind = KIND_LETTER_E; end
      2'd2: begin w_code = r_disp[7:4];  w_kind = KIND_MANT;     end
      default: begin w_code = r_disp[11:8]; w_kind = KIND_MANT;  end
    endcase
  end

  seg7_decode u_decode (
    .i_code (w_code),
    .i_kind (w_kind),
    .o_pat  (w_pat)
  );

  assign w_wrap       = (r_presc == PRESC_LAST);
  assign w_presc_next = w_wrap ? '0 : r_presc + 1'b1;
  assign w_an_onehot  = 4'b0001 << r_idx;

`ifdef SEG7_LEADING_BLANK_EN
  assign w_digit_on = !(r_idx == 2'd3 && r_disp[11:8] == 4'h0);
`else
  assign w_digit_on = 1'b1;
`endif

  // Outputs are registered from the current slot position, so they lag it by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_idx   <= 2'd0;
      r_state <= S_BLANK;
      r_seg   <= SEG_OFF;
      r_an    <= AN_OFF;
    end else begin
      r_presc <= w_presc_next;
      if (w_wrap)
        r_idx <= r_idx + 2'd1;
      r_state <= (w_presc_next >= PRESC_BLNK) ? S_DRIVE : S_BLANK;
      r_seg   <= ACT_LOW ? ~w_pat : w_pat;
      if (r_state == S_DRIVE && w_digit_on)
        r_an <= ACT_LOW ? ~w_an_onehot : w_an_onehot;
      else
        r_an <= AN_OFF;
    end
  end

  assign seg = r_seg;
  assign an  = r_an;
  assign upd = r_upd;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display: the stimulus side predicts each latch event,
// a negedge monitor checks upd timing and the scanned digit pattern every cycle.
module tb_seg7_scan_display;

  localparam int CLK_DIV    = 8;
  localparam int BLANK_CYC  = 2;
  localparam int STABLE_CNT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] lcd_in = 12'h000;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        upd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_scan_display #(
    .CLK_DIV        (CLK_DIV),
    .BLANK_CYC      (BLANK_CYC),
    .STABLE_CNT     (STABLE_CNT),
    .SEG_ACTIVE_LOW (1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .lcd_in (lcd_in),
    .seg    (seg),
    .an     (an),
    .upd    (upd)
  );

  // Clock edges seen since reset was last released.
  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    int          at_cyc;
    logic [11:0] val;
  } upd_t;
  upd_t exp_q[$];

  // Reference model: run length of identical samples and the value shown.
  logic [11:0] run_val;
  int          run_len;
  logic [11:0] model_disp;

  logic [6:0] digit_pat [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic logic [6:0] expect_pat(input int idx, input logic [11:0] d);
    int code;
    if (idx == 1) return 7'h79;
    code = (idx == 0) ? int'(d[3:0]) : (idx == 2) ? int'(d[7:4]) : int'(d[11:8]);
    if (idx == 0 && code > 5) return 7'h40;
    if (code > 9) return 7'h40;
    return digit_pat[code];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Called just before the edge that samples v; that edge is number cyc+1.
  task automatic model_step(input logic [11:0] v);
    if (run_len == STABLE_CNT && run_val != model_disp) begin
      model_disp = run_val;
      exp_q.push_back('{cyc + 1, run_val});
    end
    if (v == run_val) begin
      if (run_len <= STABLE_CNT) run_len++;
    end else begin
      run_val = v;
      run_len = 1;
    end
  endtask

  task automatic model_reset();
    run_val    = 12'h000;
    run_len    = 1;
    model_disp = 12'h000;
    exp_q.delete();
  endtask

  task automatic hold(input logic [11:0] v, input int n);
    repeat (n) begin
      @(negedge clk);
      lcd_in = v;
      model_step(v);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    model_reset();
    model_step(lcd_in);
  endtask

  task automatic mid_slot_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_an",  32'(an),  32'hF);
    check("rst_upd", 32'(upd), 32'h0);
    repeat (2) @(negedge clk);
    release_reset();
  endtask

  // Monitor: scan pattern from cycle arithmetic, upd against the scoreboard.
  logic [11:0] seen_disp = 12'h000;
  always @(negedge clk) begin
    int          p;
    int          idx;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    upd_t        e;
    if (rst) begin
      check("reset_seg", 32'(seg), 32'h7F);
      check("reset_an",  32'(an),  32'hF);
      check("reset_upd", 32'(upd), 32'h0);
      seen_disp = 12'h000;
    end else begin
      if (cyc == 0) begin
        exp_an  = 4'hF;
        exp_seg = 7'h7F;
      end else begin
        p   = (cyc - 1) % CLK_DIV;
        idx = ((cyc - 1) / CLK_DIV) % 4;
        exp_seg = ~expect_pat(idx, seen_disp);
        exp_an  = (p < BLANK_CYC) ? 4'hF : ~(4'b0001 << idx);
`ifdef SEG7_LEADING_BLANK_EN
        if (idx == 3 && seen_disp[11:8] == 4'h0) exp_an = 4'hF;
`endif
      end
      check("scan_an",  32'(an),  32'(exp_an));
      check("scan_seg", 32'(seg), 32'(exp_seg));
      if (upd) begin
        if (exp_q.size() == 0) begin
          check("upd_unexpected", 32'(upd), 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("upd_cycle", 32'(cyc), 32'(e.at_cyc));
          seen_disp = e.val;
        end
      end else if (exp_q.size() > 0 && exp_q[0].at_cyc < cyc) begin
        e = exp_q.pop_front();
        check("upd_missing", 32'(cyc), 32'(e.at_cyc));
      end
    end
  end

  initial begin
    logic [11:0] v;
    model_reset();
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    release_reset();

    hold(12'h000, 10);
    hold(12'h425, 45);
    hold(12'h999, 3);
    hold(12'h425, 45);
    hold(12'hA37, 45);
    hold(12'h071, 45);
    hold(12'h071, 2);
    hold(12'h999, 4);
    hold(12'h425, 40);

    repeat (150) begin
      v = ($urandom_range(0, 3) == 0) ? lcd_in : 12'($urandom);
      hold(v, $urandom_range(1, 8));
    end
    hold(12'h808, 40);

    mid_slot_reset();
    hold(12'h123, 45);
    hold(12'h0F6, 45);
    hold(12'h0F6, 10);

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
